// File: rtl/l1_mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_mem_responder_pkg : shared types for the LSU->L1 memory-op link |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package l1_mem_responder_pkg;

  localparam int c_ID_W = 4;

  typedef logic [63:0] data_t;

  typedef enum logic [0:0] {
    MEM_OP_LOAD  = 1'b0,
    MEM_OP_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    MMU_NONE      = 2'd0,
    MMU_UNMAPPED  = 2'd1,
    MMU_PROTECTED = 2'd2
  } mmu_exception_e;

  typedef struct packed {
    mem_op_e            op;
    data_t              addr;
    data_t              data;
    logic [c_ID_W-1:0]  id;
  } mem_req_t;

  typedef struct packed {
    mem_op_e            op;
    logic [c_ID_W-1:0]  id;
    data_t              data;
    logic               exc_valid;
    mmu_exception_e     exc;
  } mem_resp_t;

endpackage
`default_nettype wire

// File: rtl/l1_mem_responder_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_resp_queue : in-order response FIFO with per-entry countdowns  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_resp_queue
  import l1_mem_responder_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  mem_resp_t i_entry,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_valid,
  output mem_resp_t o_head
);

  localparam int         c_PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int         c_CNT_W    = $clog2(QUEUE_DEPTH + 1);
  localparam logic [3:0] c_LOAD_TMR = 4'(LATENCY - 1);

  mem_resp_t            r_ent [QUEUE_DEPTH];
  logic [3:0]           r_tmr [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;
  logic                 w_push;
  logic                 w_pop;
  logic [c_PTR_W-1:0]   w_head_nxt;
  logic [c_PTR_W-1:0]   w_tail_nxt;

  assign o_full  = (r_count == c_CNT_W'(QUEUE_DEPTH));
  assign o_valid = (r_count != '0) && (r_tmr[r_head] == 4'd0);
  assign o_head  = r_ent[r_head];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & o_valid;

  assign w_head_nxt = (r_head == c_PTR_W'(QUEUE_DEPTH - 1)) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == c_PTR_W'(QUEUE_DEPTH - 1)) ? '0 : r_tail + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= w_tail_nxt;
      if (w_pop)  r_head <= w_head_nxt;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Payload and timers need no reset: an empty queue masks them, and a push reloads them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (w_push && (r_tail == c_PTR_W'(i))) begin
        r_ent[i] <= i_entry;
        r_tmr[i] <= c_LOAD_TMR;
      end else if (r_tmr[i] != 4'd0) begin
        r_tmr[i] <= r_tmr[i] - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l1_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_mem_responder : fixed-latency L1 stand-in with fault checking   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module l1_mem_responder
  import l1_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int LATENCY      = 2,
  parameter int QUEUE_DEPTH  = 4,
  parameter int ID_W         = 4,
  parameter int RO_BASE_WORD = 0,
  parameter int RO_WORDS     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  mem_op_e                        req_op,
  input  logic [63:0]                    req_addr,
  input  data_t                          req_data,
  input  logic [ID_W-1:0]                req_id,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output mem_op_e                        resp_op,
  output logic [ID_W-1:0]                resp_id,
  output logic [63:0]                    resp_data,
  output logic                           resp_exc_valid,
  output mmu_exception_e                 resp_exc,
  input  logic                           init_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx,
  input  logic [63:0]                    init_data
);

  localparam int c_IDX_W = $clog2(DEPTH_WORDS);

  data_t               r_mem [DEPTH_WORDS];
  logic                r_active;
  mem_req_t            w_req;
  mem_resp_t           w_entry;
  mem_resp_t           w_head;
  logic [60:0]         w_word;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_unmapped;
  logic                w_protected;
  logic                w_accept;
  logic                w_full;
  logic                w_q_valid;

  assign w_req = '{op: req_op, addr: req_addr, data: req_data, id: req_id};

  assign w_word = w_req.addr[63:3];
  assign w_idx  = w_req.addr[3 +: c_IDX_W];

  // Unsigned wrap of (word - base) turns the read-only window test into one compare.
  assign w_unmapped  = (w_req.addr[2:0] != 3'd0) || (w_word >= 61'(DEPTH_WORDS));
  assign w_protected = (w_req.op == MEM_OP_STORE) &&
                       ((w_word - 61'(RO_BASE_WORD)) < 61'(RO_WORDS));

  assign req_ready = r_active & ~w_full;
  assign w_accept  = req_valid & req_ready;

  always_comb begin
    w_entry           = '0;
    w_entry.op        = w_req.op;
    w_entry.id        = w_req.id;
    w_entry.exc       = MMU_NONE;
    if (w_unmapped) begin
      w_entry.exc_valid = 1'b1;
      w_entry.exc       = MMU_UNMAPPED;
    end else if (w_protected) begin
      w_entry.exc_valid = 1'b1;
      w_entry.exc       = MMU_PROTECTED;
    end else if (w_req.op == MEM_OP_LOAD) begin
      w_entry.data      = r_mem[w_idx];
    end
  end

  // Store is ordered after the backdoor write so it wins on a same-edge collision.
  always_ff @(posedge clk) begin
    if (init_we) r_mem[init_idx] <= init_data;
    if (w_accept && (w_req.op == MEM_OP_STORE) && !w_unmapped && !w_protected)
      r_mem[w_idx] <= w_req.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_active <= 1'b0;
    else        r_active <= 1'b1;
  end

  mem_resp_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .LATENCY     (LATENCY)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_entry (w_entry),
    .i_pop   (resp_ready),
    .o_full  (w_full),
    .o_valid (w_q_valid),
    .o_head  (w_head)
  );

  assign resp_valid     = w_q_valid;
  assign resp_op        = w_q_valid ? w_head.op        : MEM_OP_LOAD;
  assign resp_id        = w_q_valid ? w_head.id        : '0;
  assign resp_data      = w_q_valid ? w_head.data      : 64'd0;
  assign resp_exc_valid = w_q_valid ? w_head.exc_valid : 1'b0;
  assign resp_exc       = w_q_valid ? w_head.exc       : MMU_UNMAPPED;

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_l1_mem_responder : directed vector bench for l1_mem_responder   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_l1_mem_responder;
  import l1_mem_responder_pkg::*;

  localparam int LATENCY = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  mem_op_e        req_op;
  logic [63:0]    req_addr;
  logic [63:0]    req_data;
  logic [3:0]     req_id;
  logic           resp_valid;
  logic           resp_ready;
  mem_op_e        resp_op;
  logic [3:0]     resp_id;
  logic [63:0]    resp_data;
  logic           resp_exc_valid;
  mmu_exception_e resp_exc;
  logic           init_we;
  logic [7:0]     init_idx;
  logic [63:0]    init_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_mem_responder #(
    .DEPTH_WORDS (256), .LATENCY (LATENCY), .QUEUE_DEPTH (4),
    .ID_W (4), .RO_BASE_WORD (0), .RO_WORDS (16)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_op (req_op),
    .req_addr (req_addr), .req_data (req_data), .req_id (req_id),
    .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_op (resp_op),
    .resp_id (resp_id), .resp_data (resp_data),
    .resp_exc_valid (resp_exc_valid), .resp_exc (resp_exc),
    .init_we (init_we), .init_idx (init_idx), .init_data (init_data)
  );

  typedef struct {
    mem_op_e        op;
    logic [63:0]    addr;
    logic [63:0]    data;
    logic [3:0]     id;
    logic [63:0]    edata;
    logic           eexcv;
    mmu_exception_e eexc;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor(input logic [7:0] idx, input logic [63:0] d);
    init_we = 1'b1; init_idx = idx; init_data = d;
    tick;
    init_we = 1'b0;
  endtask

  // Issues one request with resp_ready high and checks the single response it produces.
  task automatic issue(input mem_op_e op, input logic [63:0] addr, input logic [63:0] d,
                       input logic [3:0] id, input logic [63:0] edata, input logic eexcv,
                       input mmu_exception_e eexc);
    int lat;
    req_op = op; req_addr = addr; req_data = d; req_id = id;
    req_valid = 1'b1; resp_ready = 1'b1;
    chk("req_ready", req_ready, 1'b1);
    tick;
    req_valid = 1'b0; init_we = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LATENCY - 1));
    chk("resp_op", resp_op, op);
    chk("resp_id", resp_id, id);
    chk("resp_data", resp_data, edata);
    chk("resp_exc_valid", resp_exc_valid, eexcv);
    chk("resp_exc", resp_exc, eexcv ? eexc : MMU_NONE);
    tick;
    chk("idle_after_pop", resp_valid, 1'b0);
  endtask

  initial begin
    int bad;
    bit acc4;

    vt[0]  = '{MEM_OP_LOAD,  64'h28,  64'h0,    4'd3,  64'hDEADBEEF, 1'b0, MMU_NONE};
    vt[1]  = '{MEM_OP_STORE, 64'h100, 64'h1234, 4'd1,  64'h0,        1'b0, MMU_NONE};
    vt[2]  = '{MEM_OP_LOAD,  64'h100, 64'h0,    4'd2,  64'h1234,     1'b0, MMU_NONE};
    vt[3]  = '{MEM_OP_STORE, 64'h40,  64'h99,   4'd4,  64'h0,        1'b1, MMU_PROTECTED};
    vt[4]  = '{MEM_OP_LOAD,  64'h40,  64'h0,    4'd5,  64'h55,       1'b0, MMU_NONE};
    vt[5]  = '{MEM_OP_LOAD,  64'h800, 64'h0,    4'd6,  64'h0,        1'b1, MMU_UNMAPPED};
    vt[6]  = '{MEM_OP_LOAD,  64'h2C,  64'h0,    4'd7,  64'h0,        1'b1, MMU_UNMAPPED};
    vt[7]  = '{MEM_OP_STORE, 64'h800, 64'h5,    4'd8,  64'h0,        1'b1, MMU_UNMAPPED};
    vt[8]  = '{MEM_OP_STORE, 64'h7F8, 64'hA5,   4'd9,  64'h0,        1'b0, MMU_NONE};
    vt[9]  = '{MEM_OP_LOAD,  64'h7F8, 64'h0,    4'd10, 64'hA5,       1'b0, MMU_NONE};
    vt[10] = '{MEM_OP_STORE, 64'h78,  64'h6,    4'd11, 64'h0,        1'b1, MMU_PROTECTED};
    vt[11] = '{MEM_OP_STORE, 64'h80,  64'h77,   4'd12, 64'h0,        1'b0, MMU_NONE};
    vt[12] = '{MEM_OP_LOAD,  64'h80,  64'h0,    4'd13, 64'h77,       1'b0, MMU_NONE};

    rst_n = 1'b0; req_valid = 1'b0; req_op = MEM_OP_LOAD; req_addr = '0; req_data = '0;
    req_id = '0; resp_ready = 1'b0; init_we = 1'b0; init_idx = '0; init_data = '0;

    #12;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 64'h0);
    chk("rst_resp_id", resp_id, 4'h0);
    chk("rst_resp_exc_valid", resp_exc_valid, 1'b0);
    chk("rst_resp_op", resp_op, MEM_OP_LOAD);
    chk("rst_resp_exc", resp_exc, MMU_UNMAPPED);
    @(negedge clk); rst_n = 1'b1;
    tick; tick;

    backdoor(8'd5, 64'hDEADBEEF);
    backdoor(8'd8, 64'h55);

    for (int i = 0; i < 13; i++)
      issue(vt[i].op, vt[i].addr, vt[i].data, vt[i].id, vt[i].edata, vt[i].eexcv, vt[i].eexc);

    // Back-to-back store then load of the same word: responses on consecutive cycles.
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = MEM_OP_STORE; req_addr = 64'h108; req_data = 64'hBEEF; req_id = 4'd1;
    tick;
    req_op = MEM_OP_LOAD; req_id = 4'd2;
    tick;
    req_valid = 1'b0;
    chk("b2b_valid0", resp_valid, 1'b1);
    chk("b2b_id0", resp_id, 4'd1);
    chk("b2b_op0", resp_op, MEM_OP_STORE);
    chk("b2b_data0", resp_data, 64'h0);
    tick;
    chk("b2b_valid1", resp_valid, 1'b1);
    chk("b2b_id1", resp_id, 4'd2);
    chk("b2b_data1", resp_data, 64'hBEEF);
    tick;
    chk("b2b_idle", resp_valid, 1'b0);

    // Same-edge backdoor write vs load (load sees old) and vs store (store wins).
    backdoor(8'd21, 64'h1);
    init_we = 1'b1; init_idx = 8'd21; init_data = 64'h333;
    issue(MEM_OP_LOAD, 64'hA8, 64'h0, 4'd5, 64'h1, 1'b0, MMU_NONE);
    issue(MEM_OP_LOAD, 64'hA8, 64'h0, 4'd6, 64'h333, 1'b0, MMU_NONE);
    init_we = 1'b1; init_idx = 8'd20; init_data = 64'h111;
    issue(MEM_OP_STORE, 64'hA0, 64'h222, 4'd7, 64'h0, 1'b0, MMU_NONE);
    issue(MEM_OP_LOAD, 64'hA0, 64'h0, 4'd8, 64'h222, 1'b0, MMU_NONE);

    // Fill the queue with resp_ready low, then drain.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = MEM_OP_LOAD; req_addr = 64'h28; req_id = 4'd0;
    for (int c = 0; c < 4; c++) begin
      chk("full_fill_ready", req_ready, 1'b1);
      tick;
      req_id = 4'(c + 1);
    end
    chk("full_ready_low", req_ready, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("full_hold_valid", resp_valid, 1'b1);
      chk("full_hold_id", resp_id, 4'd0);
      chk("full_hold_data", resp_data, 64'hDEADBEEF);
      tick;
    end
    resp_ready = 1'b1;
    acc4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bit acc;
      chk("drain_valid", resp_valid, 1'b1);
      chk("drain_id", resp_id, 4'(k));
      acc = req_valid && req_ready;
      tick;
      if (acc) begin
        req_valid = 1'b0;
        acc4 = 1'b1;
      end
    end
    chk("drain_id4_accepted", acc4, 1'b1);
    chk("drain_idle", resp_valid, 1'b0);

    // Asynchronous reset with two loads pending.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = MEM_OP_LOAD; req_addr = 64'h28; req_id = 4'd1;
    tick;
    req_id = 4'd2;
    tick;
    req_valid = 1'b0;
    tick;
    chk("pre_rst_valid", resp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", resp_valid, 1'b0);
    chk("async_rst_ready", req_ready, 1'b0);
    chk("async_rst_id", resp_id, 4'd0);
    tick; tick;
    @(negedge clk); rst_n = 1'b1;
    resp_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (resp_valid !== 1'b0) bad++;
    end
    chk("post_rst_no_stale", 64'(bad), 64'd0);
    issue(MEM_OP_LOAD, 64'h100, 64'h0, 4'd9, 64'h1234, 1'b0, MMU_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/l1_mem_responder.md
Name: l1_mem_responder

Overview:
- Responder end of the LSU→L1 memory-op interface: accepts mem_op_e requests (MEM_OP_LOAD / MEM_OP_STORE) and returns in-order responses after a fixed latency.
- Backed by a word-addressed array; each response carries data or an mmu_exception_e.
- Stands in for the L1 data cache so the LSU can be built and verified before the real cache exists.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit words; valid word index is addr[63:3] < DEPTH_WORDS.
- LATENCY, 2, cycles from acceptance edge to resp_valid; legal range 1..15.
- QUEUE_DEPTH, 4, maximum outstanding (accepted, not yet popped) requests; power of two.
- ID_W, 4, request/response tag width.
- RO_BASE_WORD, 0, first word index of the read-only region.
- RO_WORDS, 16, size of the read-only region in words.

Ports:
- clk in 1 clock, rising edge.
- rst_n in 1 async active-low reset.
- req_valid in 1 request valid.
- req_ready out 1 request ready.
- req_op in mem_op_e operation.
- req_addr in 64 byte address.
- req_data in 64 (data_t) store data.
- req_id in ID_W tag.
- resp_valid out 1 response valid.
- resp_ready in 1 response consumed.
- resp_op out mem_op_e echoed operation.
- resp_id out ID_W echoed tag.
- resp_data out 64 load data; 0 for stores and faults.
- resp_exc_valid out 1 fault flag.
- resp_exc out mmu_exception_e fault kind.
- init_we in 1 backdoor write enable; bypasses protection.
- init_idx in $clog2(DEPTH_WORDS) backdoor word index.
- init_data in 64 backdoor data.

Behaviour:
- Reset is asynchronous, active-low, on a single clock domain (clk). While rst_n=0:
  - req_ready=0, resp_valid=0, resp_data=0, resp_id=0, resp_exc_valid=0.
  - resp_op=MEM_OP_LOAD, resp_exc=MMU_UNMAPPED.
  - Queue pointers and count are cleared.
  - Array contents are NOT reset.
- Reset mid-operation discards all pending entries. No stale response appears after release.
- Handshakes:
  - Accept = req_valid & req_ready.
  - req_ready = (count < QUEUE_DEPTH) when out of reset. There is no same-cycle pass-through: a full queue rejects even if a pop happens in the same cycle.
  - Pop = resp_valid & resp_ready.
- Fault check at acceptance, combinational on the request. Unmapped has priority over protected.
  - addr[2:0]≠0 or word index ≥ DEPTH_WORDS → MMU_UNMAPPED.
  - MEM_OP_STORE to index in [RO_BASE_WORD, RO_BASE_WORD+RO_WORDS) → MMU_PROTECTED.
  - A faulting request never touches the array. Its response has exc_valid=1 and data=0.
- Array access happens at the acceptance edge:
  - Store writes the word.
  - Load captures the pre-edge word value into the queue entry.
  - A load accepted after a store therefore observes the store.
- Same-edge init_we and an accepted store to the same word: the store wins. A load on that edge sees the old value.
- Queue:
  - Circular FIFO of QUEUE_DEPTH entries {op, id, data, exc_valid, exc, cnt}.
  - cnt is loaded with LATENCY-1 on accept and decrements to 0, saturating.
  - resp_valid = count>0 & head.cnt==0. With LATENCY=1, resp_valid rises the cycle immediately after the accepting edge.
  - Head outputs stay stable while resp_valid & !resp_ready.
  - Entries complete strictly in acceptance order. Fixed latency keeps timers monotonic.
  - Simultaneous accept and pop: count unchanged. Head and tail pointers wrap modulo QUEUE_DEPTH.
- When resp_valid=0, resp_data, resp_id and resp_exc_valid drive 0.

Decomposition:
- Add to package types:
  - struct mem_req_t {mem_op_e op; data_t addr; data_t data; logic [ID_W-1:0] id}.
  - struct mem_resp_t {op; id; data; exc_valid; mmu_exception_e exc}.
  - Use a fixed package ID width of 4; parameter ID_W must match it.
- One sub-module, mem_resp_queue:
  - The timed in-order FIFO, including per-entry countdowns.
  - Parent keeps the array, fault check and init port.

Test Plan:
- init_we idx 5 = 0xDEADBEEF; load addr 0x28 id 3, LATENCY=2 → resp_valid exactly 2 cycles after accept, data 0xDEADBEEF, id 3, exc_valid 0.
- Store 0x100 data 0x1234 id 1, then back-to-back load 0x100 id 2 → resp id1 (STORE, data 0), then id2 data 0x1234, consecutive cycles.
- init idx 8 = 0x55; store 0x40 → exc_valid 1, MMU_PROTECTED; following load 0x40 → 0x55.
- Load 0x800 → MMU_UNMAPPED (index 256). Load 0x2C (misaligned) → MMU_UNMAPPED. Store 0x800 → MMU_UNMAPPED, not PROTECTED.
- resp_ready=0, five loads ids 0..4 → four accepted and req_ready=0 after the fourth. Head id0 held stable ≥5 cycles. Raise resp_ready → ids 0,1,2,3 on consecutive cycles. req_ready reasserts and id4 is then accepted.
- Two loads pending, pull rst_n low mid-cycle → resp_valid=0 asynchronously. After release, no responses until a new request. Previously stored word value is retained.
